// File: rtl/instr_encoder_loader_if.sv
//------------------------------------------------------------------------------
// instr_encoder_loader_if : field-bundle handshake, imem write port and status
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [20:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;

  modport master (
    output clear, in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, done, err
  );

  modport slave (
    input  clear, in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm,
    output in_ready, imem_we, imem_addr, imem_wdata, count, done, err
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
//------------------------------------------------------------------------------
// instr_encoder_loader : assembles RV32I words from decoded fields and writes
//                        them sequentially into instruction memory from word 0
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  wire logic             clk,
  input  wire logic             rst,
  instr_encoder_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] c_fmt_r    = 3'd0;
  localparam logic [2:0] c_fmt_i    = 3'd1;
  localparam logic [2:0] c_fmt_s    = 3'd2;
  localparam logic [2:0] c_fmt_l    = 3'd3;
  localparam logic [2:0] c_fmt_b    = 3'd4;
  localparam logic [2:0] c_fmt_jal  = 3'd5;
  localparam logic [2:0] c_fmt_jalr = 3'd6;
  localparam logic [2:0] c_fmt_halt = 3'd7;

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              halt_q,  halt_d;
  logic              err_q,   err_d;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_misaligned;

  // Fields a format does not use are forced to zero; imm[0] is never encoded for B/JAL.
  function automatic logic [31:0] encode(
    input logic [2:0]  f,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [20:0] imm
  );
    logic [31:0] w;
    w = 32'h0;
    case (f)
      c_fmt_r:    w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      c_fmt_i:    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
      c_fmt_s:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      c_fmt_l:    w = {imm[11:0], rs1, f3, rd, 7'b0000011};
      c_fmt_b:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      c_fmt_jal:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      c_fmt_jalr: w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default:    w = 32'h0000007F;
    endcase
    return w;
  endfunction

  assign w_count_inc  = count_q + 1'b1;
  assign w_misaligned = ((bus.fmt == c_fmt_b) || (bus.fmt == c_fmt_jal)) && bus.imm[0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    halt_d  = halt_q;
    err_d   = err_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      addr_d  = '0;
      count_d = '0;
      halt_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            wdata_d = encode(bus.fmt, bus.rd, bus.rs1, bus.rs2,
                             bus.funct3, bus.funct7, bus.imm);
            halt_d  = (bus.fmt == c_fmt_halt);
            err_d   = err_q | w_misaligned;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          count_d = w_count_inc;
          addr_d  = addr_q + 1'b1;
          if (halt_q) begin
            state_d = S_DONE;
          end else if (w_count_inc == c_depth) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // Strobe is decoded from state so reset kills it at once; clear abandons it.
  assign bus.in_ready   = (state_q == S_IDLE) && !rst;
  assign bus.imem_we    = (state_q == S_WRITE) && !bus.clear;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.count      = count_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;

endmodule

`default_nettype wire
